multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Successor to the single-cycle opcode decoder: a Moore/Mealy FSM that sequences each instruction over several cycles (fetch, decode, execute, memory, writeback).
- Drives the shared-datapath CPU: memory port, instruction register (IR), PC, register file and ALU muxes.
- Waits on a memory-ready handshake, with a timeout.
- Adds immediate-ALU and jump classes, illegal-opcode trapping, run/idle control and a retired-instruction counter.

Parameters:
- OPCODE_W, 3, opcode width; must be >= 3.
- TIMEOUT, 16, consecutive mem_ready-low cycles in a wait state before the unit faults; 0 disables the timeout.
- CNT_W, 16, width of instr_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  run request.
- opcode  in  OPCODE_W  opcode from IR; only sampled in DECODE and EXEC_ADDR.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- ir_write  out  1  IR load.
- iord  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_to_reg  out  1  write-back source is memory data.
- reg_dst  out  1  1 selects rd, 0 selects rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 PC, 1 register A.
- alu_src_b  out  2  00 register B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instr_count  out  CNT_W  retired-instruction count; wraps.
- illegal_op  out  1  sticky fault flag.
- mem_timeout  out  1  sticky fault flag.

Behaviour:
- Opcodes: 0 R, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J; all other values are illegal. Opcodes are zero-extended to OPCODE_W.
- Reset: state IDLE; every output 0; instr_count 0; timer 0; fault flags cleared. Reset overrides everything, including mid-instruction and ERROR.
- Unlisted outputs are 0 in every state. Outputs decode from the state register, except the mem_ready-gated ones noted below.
- IDLE: all outputs 0. enable=1 -> FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - When mem_ready=1 in the same cycle: ir_write=1, pc_write=1, then -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state: R -> EXEC_R; LW, SW, ADDI -> EXEC_ADDR; BEQ -> BRANCH; J -> JUMP; illegal -> ERROR with illegal_op set.
- EXEC_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEM_RD; SW -> MEM_WR; ADDI -> WB_I.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. -> WB_R.
- MEM_RD: mem_read=1, iord=1. mem_ready=1 -> WB_MEM.
- MEM_WR: mem_write=1, iord=1. mem_ready=1 -> terminal.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0. -> terminal.
- WB_R: reg_write=1, reg_dst=1. -> terminal.
- WB_I: reg_write=1, reg_dst=0. -> terminal.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. -> terminal.
- JUMP: pc_write=1, pc_source=10. -> terminal.
- Terminal cycle (the state's last cycle: MEM_WR with mem_ready=1, WB_*, BRANCH, JUMP):
  - instr_done=1 and instr_count+1 (wraps at 2^CNT_W).
  - Next state is FETCH if enable=1, else IDLE.
  - enable is not checked anywhere else; an instruction in flight always completes.
- Latency with mem_ready held high: R 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3 cycles. Each mem_ready-low cycle adds one.
- Timer and timeout:
  - Wait states are FETCH, MEM_RD and MEM_WR. The timer clears on entry to any wait state.
  - The timer increments each cycle a wait state sees mem_ready=0.
  - If timer==TIMEOUT-1 and mem_ready=0 -> ERROR with mem_timeout set, so TIMEOUT low cycles cause a fault.
  - mem_ready=1 always wins over the timeout.
- ERROR: all control outputs 0; fault flag stays high; no exit except reset.

Decomposition:
- Shared package mcu_pkg holds:
  - state enum;
  - opcode constants OP_R..OP_J;
  - alu_src_b, alu_op and pc_source encodings.
- One sub-module, mcu_wait_timer: the timeout counter with clear, increment and expired outputs.

Test Plan:
- R-type stream, mem_ready=1, enable=1, opcode=0 -> FETCH/DECODE/EXEC_R/WB_R repeating; instr_done every 4th cycle; reg_dst=1 and reg_write=1 in WB_R; instr_count reaches 3 after 12 cycles.
- LW with mem_ready low 2 cycles in MEM_RD -> mem_read=1 and iord=1 held 3 cycles; retires in 7 cycles; mem_to_reg=1 in WB_MEM.
- SW, BEQ, J, ADDI back to back -> retire at cycles 4, 7, 10, 14; pc_write_cond=1 with pc_source=01 in BRANCH; pc_write=1 with pc_source=10 in JUMP.
- opcode=7 at DECODE -> ERROR on the next cycle, illegal_op=1, all controls 0; enable toggling has no effect; reset -> IDLE, flag cleared.
- TIMEOUT=16, mem_ready=0 in FETCH -> mem_timeout=1 after exactly 16 low cycles; with mem_ready=1 on the 16th cycle instead -> normal DECODE, no fault.
- enable dropped mid-LW -> LW completes, then IDLE with all outputs 0; reset asserted in MEM_RD -> IDLE next cycle, instr_count=0; CNT_W=2 -> count wraps 3->0 on the 4th retirement.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the FSM state enum, the opcode constants, the datapath mux
// encodings and the per-state control decode used by the top level.
package mcu_pkg;

  // Base opcodes; wider opcode fields zero-extend these.
  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_BEQ  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_J    = 3'd5;

  // ALU operand B select.
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU operation select.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_ADDR,
    ST_EXEC_R,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_MEM,
    ST_WB_R,
    ST_WB_I,
    ST_BRANCH,
    ST_JUMP,
    ST_ERROR
  } state_e;

  // Control word that depends only on the state (mem_ready-gated
  // strobes are added separately at the top level).
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  // States that stall on the memory handshake.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

  // State-decoded control word.
  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.iord      = 1'b0;
        c.alu_src_a = 1'b0;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        c.alu_src_a = 1'b0;
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      ST_EXEC_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      ST_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_dst    = 1'b0;
        c.instr_done = 1'b1;
      end
      ST_WB_R: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_WB_I: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b0;
        c.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bus between the multicycle control unit and the shared datapath.
// master: the control unit (takes run/opcode/handshake, drives controls).
// slave:  the datapath / environment side.
interface multicycle_control_unit_if #(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned CNT_W    = 16
);
  logic                enable;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;

  logic                pc_write;
  logic                pc_write_cond;
  logic [1:0]          pc_source;
  logic                ir_write;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                instr_done;
  logic [CNT_W-1:0]    instr_count;
  logic                illegal_op;
  logic                mem_timeout;

  modport master (
    input  enable, opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
           mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, instr_count, illegal_op, mem_timeout
  );

  modport slave (
    output enable, opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
           mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, instr_count, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mcu_wait_timer.sv
// Consecutive-stall counter for memory wait states.
// Ports: clk, reset (sync, active-high); clear_i restarts the count,
// inc_i counts one stalled cycle; expired_o is high while the count has
// reached TIMEOUT-1 (never when TIMEOUT is 0).
module mcu_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned   TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [TW-1:0] count_q, count_d;
  logic          expired_q;

  // Clear has priority so a fresh wait state always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + TW'(1);
    end
  end

  // expired_q mirrors (count_q == LAST) without a compare on the output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      expired_q <= (TIMEOUT == 1);
    end else begin
      count_q   <= count_d;
      expired_q <= (TIMEOUT != 0) && (count_d == LAST);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences each instruction through fetch,
// decode, execute, memory and writeback for a shared-datapath CPU.
// Ports: clk, reset (sync, active-high), bus (master side of
// multicycle_control_unit_if: enable/opcode/mem_ready in, datapath
// controls, instr_done, instr_count and sticky fault flags out).
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  multicycle_control_unit_if.master         bus
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q, timeout_q;

  logic retire_c, set_illegal_c, set_timeout_c;
  logic tmr_clear_c, tmr_inc_c, tmr_expired;
  logic fetch_ack_c, store_ack_c;

  function automatic logic op_is(input logic [OPCODE_W-1:0] op,
                                 input logic [2:0]          code);
    return op == OPCODE_W'(code);
  endfunction

  // Next-state decode; retire_c marks an instruction's final cycle.
  always_comb begin
    state_d       = state_q;
    retire_c      = 1'b0;
    set_illegal_c = 1'b0;
    set_timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d       = ST_ERROR;
          set_timeout_c = 1'b1;
        end
      end
      ST_DECODE: begin
        if (op_is(bus.opcode, OP_R)) begin
          state_d = ST_EXEC_R;
        end else if (op_is(bus.opcode, OP_LW) || op_is(bus.opcode, OP_SW) ||
                     op_is(bus.opcode, OP_ADDI)) begin
          state_d = ST_EXEC_ADDR;
        end else if (op_is(bus.opcode, OP_BEQ)) begin
          state_d = ST_BRANCH;
        end else if (op_is(bus.opcode, OP_J)) begin
          state_d = ST_JUMP;
        end else begin
          state_d       = ST_ERROR;
          set_illegal_c = 1'b1;
        end
      end
      ST_EXEC_ADDR: begin
        // Opcode is re-read here to pick the memory/immediate path; a value
        // that changed to something else is trapped like any illegal opcode.
        if (op_is(bus.opcode, OP_LW)) begin
          state_d = ST_MEM_RD;
        end else if (op_is(bus.opcode, OP_SW)) begin
          state_d = ST_MEM_WR;
        end else if (op_is(bus.opcode, OP_ADDI)) begin
          state_d = ST_WB_I;
        end else begin
          state_d       = ST_ERROR;
          set_illegal_c = 1'b1;
        end
      end
      ST_EXEC_R: state_d = ST_WB_R;
      ST_MEM_RD: begin
        if (bus.mem_ready) begin
          state_d = ST_WB_MEM;
        end else if (tmr_expired) begin
          state_d       = ST_ERROR;
          set_timeout_c = 1'b1;
        end
      end
      ST_MEM_WR: begin
        if (bus.mem_ready) begin
          retire_c = 1'b1;
        end else if (tmr_expired) begin
          state_d       = ST_ERROR;
          set_timeout_c = 1'b1;
        end
      end
      ST_WB_MEM, ST_WB_R, ST_WB_I, ST_BRANCH, ST_JUMP: retire_c = 1'b1;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
    // enable only matters between instructions.
    if (retire_c) state_d = bus.enable ? ST_FETCH : ST_IDLE;
  end

  // Timer restarts on every entry into a wait state, counts stalled cycles.
  always_comb begin
    tmr_clear_c = is_wait_state(state_d) && (state_d != state_q);
    tmr_inc_c   = is_wait_state(state_q) && !bus.mem_ready;
  end

  mcu_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmr_clear_c),
    .inc_i     (tmr_inc_c),
    .expired_o (tmr_expired)
  );

  // State, registered control word, retire counter and sticky faults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
      if (retire_c)      count_q   <= count_q + CNT_W'(1);
      if (set_illegal_c) illegal_q <= 1'b1;
      if (set_timeout_c) timeout_q <= 1'b1;
    end
  end

  // Strobes that must land in the same cycle memory completes.
  assign fetch_ack_c = (state_q == ST_FETCH)  && bus.mem_ready;
  assign store_ack_c = (state_q == ST_MEM_WR) && bus.mem_ready;

  assign bus.pc_write      = ctrl_q.pc_write | fetch_ack_c;
  assign bus.ir_write      = fetch_ack_c;
  assign bus.instr_done    = ctrl_q.instr_done | store_ack_c;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.iord          = ctrl_q.iord;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.instr_count   = count_q;
  assign bus.illegal_op    = illegal_q;
  assign bus.mem_timeout   = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed instruction streams, an
// instruction-level reference model checked every cycle, and literal
// expectations on retire cycles, counters and fault flags.
module tb_multicycle_control_unit;

  localparam int unsigned OW = 3;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic reset;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(OW), .CNT_W(CW)) bus ();
  multicycle_control_unit_if #(.OPCODE_W(OW), .CNT_W(2))  bus2 ();

  multicycle_control_unit #(.OPCODE_W(OW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow-counter copy driven by the same inputs, for wrap checking.
  multicycle_control_unit #(.OPCODE_W(OW), .TIMEOUT(TO), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  assign bus2.enable    = bus.enable;
  assign bus2.opcode    = bus.opcode;
  assign bus2.mem_ready = bus.mem_ready;

  logic [16:0] act_ctrl, act_ctrl2;
  assign act_ctrl = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.ir_write,
                     bus.iord, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                     bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                     bus.alu_op, bus.instr_done};
  assign act_ctrl2 = {bus2.pc_write, bus2.pc_write_cond, bus2.pc_source, bus2.ir_write,
                      bus2.iord, bus2.mem_read, bus2.mem_write, bus2.mem_to_reg,
                      bus2.reg_dst, bus2.reg_write, bus2.alu_src_a, bus2.alu_src_b,
                      bus2.alu_op, bus2.instr_done};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An instruction is a string of phases: F fetch, D decode, A address,
  // X R-execute, L load, S store, M load-writeback, W R-writeback,
  // I imm-writeback, B branch, J jump. F, L and S wait on mem_ready.
  int          m_mode = 0;     // 0 idle, 1 running, 2 faulted
  string       m_path = "FD";
  int          m_k    = 0;
  int unsigned m_low  = 0;
  int unsigned m_cnt  = 0;
  logic        m_ill  = 1'b0;
  logic        m_tmo  = 1'b0;

  function automatic string path_of(input logic [2:0] op);
    case (op)
      3'd0:    return "FDXW";
      3'd1:    return "FDALM";
      3'd2:    return "FDAS";
      3'd3:    return "FDB";
      3'd4:    return "FDAI";
      3'd5:    return "FDJ";
      default: return "";
    endcase
  endfunction

  function automatic logic is_wait(input byte ch);
    return (ch == "F") || (ch == "L") || (ch == "S");
  endfunction

  // {pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read, mem_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, instr_done}
  function automatic logic [16:0] exp_ctrl(input byte ch, input logic rdy, input logic dn);
    logic pcw, pwc, irw, iord, mrd, mwr, m2r, rdst, rwr, sa;
    logic [1:0] ps, sb, aop;
    {pcw, pwc, irw, iord, mrd, mwr, m2r, rdst, rwr, sa} = '0;
    {ps, sb, aop} = '0;
    case (ch)
      "F": begin mrd = 1'b1; sb = 2'b01; pcw = rdy; irw = rdy; end
      "D": sb = 2'b11;
      "A": begin sa = 1'b1; sb = 2'b10; end
      "X": begin sa = 1'b1; aop = 2'b10; end
      "L": begin mrd = 1'b1; iord = 1'b1; end
      "S": begin mwr = 1'b1; iord = 1'b1; end
      "M": begin rwr = 1'b1; m2r = 1'b1; end
      "W": begin rwr = 1'b1; rdst = 1'b1; end
      "I": rwr = 1'b1;
      "B": begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; ps = 2'b01; end
      "J": begin pcw = 1'b1; ps = 2'b10; end
      default: ;
    endcase
    return {pcw, pwc, ps, irw, iord, mrd, mwr, m2r, rdst, rwr, sa, sb, aop, dn};
  endfunction

  // Compare every cycle, then advance the model with this cycle's inputs.
  initial begin
    byte  cur;
    logic rdy, dn;
    forever begin
      @(negedge clk);
      rdy = bus.mem_ready;
      cur = (m_mode == 1) ? m_path[m_k] : "i";
      dn  = (m_mode == 1) && (cur != "D") && (m_k == m_path.len() - 1) &&
            (!is_wait(cur) || rdy);
      if (chk_en) begin
        chk("ctrl",    32'(act_ctrl),  32'(exp_ctrl(cur, rdy, dn)));
        chk("ctrl2",   32'(act_ctrl2), 32'(exp_ctrl(cur, rdy, dn)));
        chk("count",   32'(bus.instr_count),  m_cnt & 32'hFFFF);
        chk("count2",  32'(bus2.instr_count), m_cnt % 4);
        chk("illegal", 32'(bus.illegal_op),   32'(m_ill));
        chk("timeout", 32'(bus.mem_timeout),  32'(m_tmo));
      end
      if (reset) begin
        m_mode = 0; m_cnt = 0; m_ill = 1'b0; m_tmo = 1'b0; m_low = 0;
      end else if (m_mode == 0) begin
        if (bus.enable) begin m_mode = 1; m_path = "FD"; m_k = 0; m_low = 0; end
      end else if (m_mode == 1) begin
        if (is_wait(cur) && !rdy) begin
          if (TO != 0 && m_low + 1 == TO) begin m_mode = 2; m_tmo = 1'b1; end
          else m_low++;
        end else if (cur == "D" && path_of(bus.opcode) == "") begin
          m_mode = 2; m_ill = 1'b1;
        end else begin
          if (cur == "D") m_path = path_of(bus.opcode);
          if (m_k == m_path.len() - 1) begin
            m_cnt++;
            if (bus.enable) begin m_path = "FD"; m_k = 0; end
            else m_mode = 0;
          end else begin
            m_k++;
          end
          m_low = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int unsigned cyc_idx;
  int unsigned done_q[$];

  task automatic seg_start();
    cyc_idx = 0;
    done_q.delete();
  endtask

  // One clock cycle with the given inputs; logs retire cycles.
  task automatic step(input logic r, input logic en, input logic [2:0] op, input logic rdy);
    cyc_idx++;
    reset         = r;
    bus.enable    = en;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    @(negedge clk);
    if (bus.instr_done === 1'b1) done_q.push_back(cyc_idx);
    @(posedge clk);
    #1;
  endtask

  logic [2:0] mix_op [14];

  initial begin
    reset = 1'b1; bus.enable = 1'b0; bus.opcode = '0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_ctrl",  32'(act_ctrl), 32'd0);
    chk("rst_count", 32'(bus.instr_count), 32'd0);
    chk("rst_flags", 32'({bus.illegal_op, bus.mem_timeout}), 32'd0);

    // R-type stream from IDLE.
    step(1'b0, 1'b1, 3'd0, 1'b1);
    seg_start();
    repeat (12) step(1'b0, 1'b1, 3'd0, 1'b1);
    chk("r_count3", 32'(bus.instr_count), 32'd3);
    chk("r_ndone",  32'(done_q.size()), 32'd3);
    chk("r_done0",  done_q[0], 32'd4);
    chk("r_done2",  done_q[2], 32'd12);

    // LW with two stalled MEM_RD cycles.
    seg_start();
    step(1'b0, 1'b1, 3'd1, 1'b1);
    step(1'b0, 1'b1, 3'd1, 1'b1);
    step(1'b0, 1'b1, 3'd1, 1'b1);
    step(1'b0, 1'b1, 3'd1, 1'b0);
    step(1'b0, 1'b1, 3'd1, 1'b0);
    step(1'b0, 1'b1, 3'd1, 1'b1);
    step(1'b0, 1'b1, 3'd1, 1'b1);
    chk("lw_done7", done_q[0], 32'd7);
    chk("lw_count", 32'(bus.instr_count), 32'd4);
    chk("wrap4",    32'(bus2.instr_count), 32'd0);

    // SW, BEQ, J, ADDI back to back.
    mix_op = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3,
               3'd5, 3'd5, 3'd5, 3'd4, 3'd4, 3'd4, 3'd4};
    seg_start();
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, mix_op[i], 1'b1);
    chk("mix_n",  32'(done_q.size()), 32'd4);
    chk("mix_sw", done_q[0], 32'd4);
    chk("mix_bq", done_q[1], 32'd7);
    chk("mix_j",  done_q[2], 32'd10);
    chk("mix_ai", done_q[3], 32'd14);

    // enable dropped mid-LW: instruction completes, then IDLE.
    seg_start();
    step(1'b0, 1'b1, 3'd1, 1'b1);
    step(1'b0, 1'b1, 3'd1, 1'b1);
    step(1'b0, 1'b0, 3'd1, 1'b1);
    step(1'b0, 1'b0, 3'd1, 1'b1);
    step(1'b0, 1'b0, 3'd1, 1'b1);
    step(1'b0, 1'b0, 3'd1, 1'b1);
    chk("drop_done5", done_q[0], 32'd5);
    chk("drop_idle",  32'(act_ctrl), 32'd0);
    chk("drop_count", 32'(bus.instr_count), 32'd9);

    // Timeout near miss: ready on the 16th cycle, then a full R.
    step(1'b0, 1'b1, 3'd0, 1'b1);
    repeat (15) step(1'b0, 1'b1, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'd0, 1'b1);
    chk("near_decode", 32'(bus.alu_src_b), 32'd3);
    repeat (3) step(1'b0, 1'b1, 3'd0, 1'b1);
    chk("near_nofault", 32'(bus.mem_timeout), 32'd0);

    // Full timeout in FETCH.
    repeat (15) step(1'b0, 1'b1, 3'd0, 1'b0);
    chk("tmo_15", 32'(bus.mem_timeout), 32'd0);
    step(1'b0, 1'b1, 3'd0, 1'b0);
    chk("tmo_16", 32'(bus.mem_timeout), 32'd1);
    chk("tmo_ctrl", 32'(act_ctrl), 32'd0);
    step(1'b0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b1, 3'd0, 1'b1);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    chk("tmo_clr", 32'(bus.mem_timeout), 32'd0);

    // Illegal opcode trap.
    step(1'b0, 1'b1, 3'd7, 1'b1);
    step(1'b0, 1'b1, 3'd7, 1'b1);
    step(1'b0, 1'b1, 3'd7, 1'b1);
    chk("ill_set",  32'(bus.illegal_op), 32'd1);
    chk("ill_ctrl", 32'(act_ctrl), 32'd0);
    step(1'b0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b1, 3'd0, 1'b1);
    chk("ill_stuck", 32'(bus.illegal_op), 32'd1);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    chk("ill_clr", 32'(bus.illegal_op), 32'd0);

    // Reset asserted while stalled in MEM_RD.
    step(1'b0, 1'b1, 3'd1, 1'b1);
    step(1'b0, 1'b1, 3'd1, 1'b1);
    step(1'b0, 1'b1, 3'd1, 1'b1);
    step(1'b0, 1'b1, 3'd1, 1'b1);
    chk("rd_stall", 32'({bus.mem_read, bus.iord}), 32'd3);
    step(1'b1, 1'b1, 3'd1, 1'b0);
    chk("rd_rst_cnt",  32'(bus.instr_count), 32'd0);
    chk("rd_rst_ctrl", 32'(act_ctrl), 32'd0);
    step(1'b0, 1'b0, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
